// File: rtl/control_fsm_if.sv
// ============================================================================
//  Module      : control_fsm_pkg / control_fsm_if
//  Description : RV32I control types and the control-to-datapath interface.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package control_fsm_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
    } alu_ops;

    typedef enum logic [2:0] {
        beq = 3'b000, bne = 3'b001, blt = 3'b100,
        bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        f3_add, f3_sll, f3_slt, f3_sltu, f3_xor, f3_sr, f3_or, f3_and
    } arith_funct3_t;

    typedef enum logic [2:0] {
        f3_lb = 3'b000, f3_lh = 3'b001, f3_lw = 3'b010,
        f3_lbu = 3'b100, f3_lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        f3_sb = 3'b000, f3_sh = 3'b001, f3_sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2
    } pcmux_sel_t;

    typedef enum logic {
        marmux_pc_out, marmux_alu_out
    } marmux_sel_t;

    typedef enum logic {
        cmpmux_rs2_out, cmpmux_i_imm
    } cmpmux_sel_t;

    typedef enum logic {
        alumux1_rs1_out, alumux1_pc_out
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm, alumux2_u_imm, alumux2_b_imm,
        alumux2_s_imm, alumux2_j_imm, alumux2_rs2_out
    } alumux2_sel_t;

    typedef enum logic [3:0] {
        regfilemux_alu_out, regfilemux_br_en, regfilemux_u_imm, regfilemux_lw,
        regfilemux_pc_plus4, regfilemux_lb, regfilemux_lbu, regfilemux_lh,
        regfilemux_lhu
    } regfilemux_sel_t;

endpackage

interface control_fsm_if;
    import control_fsm_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            br_en;
    logic [31:0]     mem_address;
    logic            mem_resp;

    logic            load_pc;
    logic            load_ir;
    logic            load_regfile;
    logic            load_mar;
    logic            load_mdr;
    logic            load_data_out;
    pcmux_sel_t      pcmux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    cmpmux_sel_t     cmpmux_sel;
    alu_ops          aluop;
    branch_funct3_t  cmp_op;
    logic            mem_read;
    logic            mem_write;
    logic [3:0]      mem_byte_enable;
    logic            halted;

    modport master (
        input  opcode, funct3, funct7, br_en, mem_address, mem_resp,
        output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
               pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
               cmpmux_sel, aluop, cmp_op, mem_read, mem_write, mem_byte_enable,
               halted
    );

    modport slave (
        output opcode, funct3, funct7, br_en, mem_address, mem_resp,
        input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
               pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
               cmpmux_sel, aluop, cmp_op, mem_read, mem_write, mem_byte_enable,
               halted
    );

endinterface

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
//  Module      : control_fsm
//  Description : Multi-cycle RV32I control unit driving datapath enables/selects.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_fsm
    import control_fsm_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.master bus
);

    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_IMM, S_REG, S_LUI, S_AUIPC, S_BR, S_JAL, S_JALR,
        S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2, S_HALT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH1;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs are gated by rst so a request in flight drops the moment reset asserts.
    always_comb begin
        w_next_state        = r_state;
        bus.load_pc         = 1'b0;
        bus.load_ir         = 1'b0;
        bus.load_regfile    = 1'b0;
        bus.load_mar        = 1'b0;
        bus.load_mdr        = 1'b0;
        bus.load_data_out   = 1'b0;
        bus.pcmux_sel       = pcmux_pc_plus4;
        bus.alumux1_sel     = alumux1_rs1_out;
        bus.alumux2_sel     = alumux2_i_imm;
        bus.regfilemux_sel  = regfilemux_alu_out;
        bus.marmux_sel      = marmux_pc_out;
        bus.cmpmux_sel      = cmpmux_rs2_out;
        bus.aluop           = alu_add;
        bus.cmp_op          = beq;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 4'b0000;
        bus.halted          = 1'b0;

        if (rst) begin
            case (r_state)
                S_FETCH1: begin
                    bus.load_mar   = 1'b1;
                    bus.marmux_sel = marmux_pc_out;
                    w_next_state   = S_FETCH2;
                end
                S_FETCH2: begin
                    bus.mem_read = 1'b1;
                    bus.load_mdr = 1'b1;
                    if (bus.mem_resp) begin
                        w_next_state = S_FETCH3;
                    end
                end
                S_FETCH3: begin
                    bus.load_ir  = 1'b1;
                    w_next_state = S_DECODE;
                end
                S_DECODE: begin
                    case (bus.opcode)
                        op_imm:   w_next_state = S_IMM;
                        op_reg:   w_next_state = S_REG;
                        op_lui:   w_next_state = S_LUI;
                        op_auipc: w_next_state = S_AUIPC;
                        op_br:    w_next_state = S_BR;
                        op_jal:   w_next_state = S_JAL;
                        op_jalr:  w_next_state = S_JALR;
                        op_load,
                        op_store: w_next_state = S_CALC_ADDR;
                        default: begin
                            if (TRAP_ON_ILLEGAL) begin
                                w_next_state = S_HALT;
                            end else begin
                                // No free execute state for a no-op, so PC+4 retires here.
                                bus.load_pc   = 1'b1;
                                bus.pcmux_sel = pcmux_pc_plus4;
                                w_next_state  = S_FETCH1;
                            end
                        end
                    endcase
                end
                S_IMM, S_REG: begin
                    bus.load_regfile = 1'b1;
                    bus.load_pc      = 1'b1;
                    bus.pcmux_sel    = pcmux_pc_plus4;
                    bus.alumux2_sel  = (r_state == S_IMM) ? alumux2_i_imm : alumux2_rs2_out;
                    bus.aluop        = alu_ops'(bus.funct3);
                    case (bus.funct3)
                        f3_slt, f3_sltu: begin
                            bus.regfilemux_sel = regfilemux_br_en;
                            bus.cmp_op         = (bus.funct3 == f3_slt) ? blt : bltu;
                            bus.cmpmux_sel     = (r_state == S_IMM) ? cmpmux_i_imm : cmpmux_rs2_out;
                        end
                        f3_sr: begin
                            if (bus.funct7[5]) begin
                                bus.aluop = alu_sra;
                            end
                        end
                        f3_add: begin
                            if ((r_state == S_REG) && bus.funct7[5]) begin
                                bus.aluop = alu_sub;
                            end
                        end
                        default: ;
                    endcase
                    w_next_state = S_FETCH1;
                end
                S_LUI: begin
                    bus.regfilemux_sel = regfilemux_u_imm;
                    bus.load_regfile   = 1'b1;
                    bus.load_pc        = 1'b1;
                    w_next_state       = S_FETCH1;
                end
                S_AUIPC: begin
                    bus.alumux1_sel    = alumux1_pc_out;
                    bus.alumux2_sel    = alumux2_u_imm;
                    bus.regfilemux_sel = regfilemux_alu_out;
                    bus.load_regfile   = 1'b1;
                    bus.load_pc        = 1'b1;
                    w_next_state       = S_FETCH1;
                end
                S_BR: begin
                    bus.alumux1_sel = alumux1_pc_out;
                    bus.alumux2_sel = alumux2_b_imm;
                    bus.cmpmux_sel  = cmpmux_rs2_out;
                    bus.cmp_op      = branch_funct3_t'(bus.funct3);
                    bus.pcmux_sel   = bus.br_en ? pcmux_alu_out : pcmux_pc_plus4;
                    bus.load_pc     = 1'b1;
                    w_next_state    = S_FETCH1;
                end
                S_JAL: begin
                    bus.alumux1_sel    = alumux1_pc_out;
                    bus.alumux2_sel    = alumux2_j_imm;
                    bus.pcmux_sel      = pcmux_alu_out;
                    bus.regfilemux_sel = regfilemux_pc_plus4;
                    bus.load_regfile   = 1'b1;
                    bus.load_pc        = 1'b1;
                    w_next_state       = S_FETCH1;
                end
                S_JALR: begin
                    bus.alumux1_sel    = alumux1_rs1_out;
                    bus.alumux2_sel    = alumux2_i_imm;
                    bus.pcmux_sel      = pcmux_alu_mod2;
                    bus.regfilemux_sel = regfilemux_pc_plus4;
                    bus.load_regfile   = 1'b1;
                    bus.load_pc        = 1'b1;
                    w_next_state       = S_FETCH1;
                end
                S_CALC_ADDR: begin
                    bus.marmux_sel = marmux_alu_out;
                    bus.load_mar   = 1'b1;
                    if (bus.opcode == op_store) begin
                        bus.alumux2_sel   = alumux2_s_imm;
                        bus.load_data_out = 1'b1;
                        w_next_state      = S_ST1;
                    end else begin
                        bus.alumux2_sel = alumux2_i_imm;
                        w_next_state    = S_LD1;
                    end
                end
                S_LD1: begin
                    bus.mem_read = 1'b1;
                    bus.load_mdr = 1'b1;
                    if (bus.mem_resp) begin
                        w_next_state = S_LD2;
                    end
                end
                S_LD2: begin
                    bus.load_regfile = 1'b1;
                    bus.load_pc      = 1'b1;
                    case (bus.funct3)
                        f3_lb:   bus.regfilemux_sel = regfilemux_lb;
                        f3_lh:   bus.regfilemux_sel = regfilemux_lh;
                        f3_lbu:  bus.regfilemux_sel = regfilemux_lbu;
                        f3_lhu:  bus.regfilemux_sel = regfilemux_lhu;
                        default: bus.regfilemux_sel = regfilemux_lw;
                    endcase
                    w_next_state = S_FETCH1;
                end
                S_ST1: begin
                    bus.mem_write = 1'b1;
                    case (bus.funct3)
                        f3_sb:   bus.mem_byte_enable = 4'b0001 << bus.mem_address[1:0];
                        f3_sh:   bus.mem_byte_enable = 4'b0011 << {bus.mem_address[1], 1'b0};
                        f3_sw:   bus.mem_byte_enable = 4'b1111;
                        default: bus.mem_byte_enable = 4'b0000;
                    endcase
                    if (bus.mem_resp) begin
                        w_next_state = S_ST2;
                    end
                end
                S_ST2: begin
                    bus.load_pc  = 1'b1;
                    w_next_state = S_FETCH1;
                end
                S_HALT: begin
                    bus.halted = 1'b1;
                end
                default: begin
                    w_next_state = S_FETCH1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
